// File: rtl/subtractor_4bit_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package subtractor_4bit_serial_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/subtractor_4bit_serial_full_subtractor_1bit.sv
// One-bit full subtractor: d = x - y - bi, with bo set when the bit position must borrow.
module full_subtractor_1bit
    import subtractor_4bit_serial_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/subtractor_4bit_serial.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single full subtractor.
// Optional SUB_OVERFLOW_EN adds a signed-overflow output ovf.
module subtractor_4bit_serial
    import subtractor_4bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             borrow_reg, borrow_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             fs_d;
    logic             fs_bo;
    logic             last_bit;

    full_subtractor_1bit u_fs (
        .x  (a_reg[0]),
        .y  (b_reg[0]),
        .bi (borrow_reg),
        .d  (fs_d),
        .bo (fs_bo)
    );

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

`ifdef SUB_OVERFLOW_EN
    logic ovf_reg, ovf_next;
`endif

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;
        cnt_next    = cnt_reg;
`ifdef SUB_OVERFLOW_EN
        ovf_next    = ovf_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = SHIFT;
                    a_next      = a;
                    b_next      = b;
                    borrow_next = bin;
                    cnt_next    = '0;
                end
            end
            SHIFT: begin
                // Operands drain from the LSB end while results enter at the MSB end,
                // so after WIDTH steps diff_reg holds the word in natural order.
                a_next      = a_reg >> 1;
                b_next      = b_reg >> 1;
                diff_next   = {fs_d, diff_reg[WIDTH-1:1]};
                borrow_next = fs_bo;
                cnt_next    = cnt_reg + 1'b1;
                if (last_bit) begin
                    state_next = DONE;
`ifdef SUB_OVERFLOW_EN
                    // Signed overflow: borrow into the sign bit differs from borrow out of it.
                    ovf_next   = borrow_reg ^ fs_bo;
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
`ifdef SUB_OVERFLOW_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
            cnt_reg    <= cnt_next;
`ifdef SUB_OVERFLOW_EN
            ovf_reg    <= ovf_next;
`endif
        end
    end

    assign diff = diff_reg;
    // The borrow register only moves during SHIFT, so it doubles as the held borrow-out.
    assign bout = borrow_reg;
    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
`ifdef SUB_OVERFLOW_EN
    assign ovf  = ovf_reg;
`endif

endmodule
